gpio_pwm_apb_regs: RTL and testbench

APB3 slave register bank that sits directly upstream of the GPIO/PWM top level. Holds GPIO mode selects, GPIO output data and per-timer PWM enables, periods and duties, and drives them straight into that block. PWM period/duty writes go to shadow registers and are committed to the live outputs on command. Also synchronises returning `gpio_input`, latches rising-edge events and raises a level interrupt.

---
 rtl/gpio_pwm_pkg.sv | 40 ++++
 rtl/gpio_pwm_apb_regs_if.sv | 23 ++
 rtl/gpio_in_sync.sv | 31 +++
 rtl/gpio_pwm_apb_regs.sv | 176 +++++++++++++++++
 tb/tb_gpio_pwm_apb_regs.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pwm_pkg.sv
// Shared register map, shadow-bank geometry and decode select codes for the
// GPIO/PWM APB register bank.
package gpio_pwm_pkg;

  localparam int unsigned APB_DATA_W = 32;

  localparam int unsigned OFF_OUT      = 32'h00;
  localparam int unsigned OFF_IN       = 32'h04;
  localparam int unsigned OFF_IN_SEL   = 32'h08;
  localparam int unsigned OFF_AF_SEL   = 32'h0C;
  localparam int unsigned OFF_OD_SEL   = 32'h10;
  localparam int unsigned OFF_LO_SEL   = 32'h14;
  localparam int unsigned OFF_PWM_EN   = 32'h18;
  localparam int unsigned OFF_PWM_UPD  = 32'h1C;
  localparam int unsigned OFF_IRQ_EN   = 32'h20;
  localparam int unsigned OFF_IRQ_STAT = 32'h24;

  localparam int unsigned SHADOW_BASE   = 32'h40;
  localparam int unsigned SHADOW_STRIDE = 8;

  localparam int unsigned IRQ_STAT_W = 32;
  localparam int unsigned PWM_UPD_W  = 8;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_OUT,
    SEL_IN,
    SEL_IN_SEL,
    SEL_AF_SEL,
    SEL_OD_SEL,
    SEL_LO_SEL,
    SEL_PWM_EN,
    SEL_PWM_UPD,
    SEL_IRQ_EN,
    SEL_IRQ_STAT,
    SEL_MAX,
    SEL_DUTY
  } reg_sel_e;

endpackage

// File: rtl/gpio_pwm_apb_regs_if.sv
// APB3 request/response bundle between the bus master and the register bank.
interface gpio_pwm_apb_regs_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/gpio_in_sync.sv
// Two-flop synchroniser for asynchronous pin inputs, plus a third flop that
// doubles as the readable input value and the edge-detect history.
module gpio_in_sync #(
  parameter int unsigned GPIO_PORT_NUM = 32
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [GPIO_PORT_NUM-1:0] gpio_input,
  output logic [GPIO_PORT_NUM-1:0] sync_val,
  output logic [GPIO_PORT_NUM-1:0] rise
);

  logic [GPIO_PORT_NUM-1:0] meta;
  logic [GPIO_PORT_NUM-1:0] stage2;

  // rise is a registered one-cycle pulse, aligned with sync_val turning 1
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      meta     <= '0;
      stage2   <= '0;
      sync_val <= '0;
      rise     <= '0;
    end else begin
      meta     <= gpio_input;
      stage2   <= meta;
      sync_val <= stage2;
      rise     <= stage2 & ~sync_val;
    end
  end

endmodule

// File: rtl/gpio_pwm_apb_regs.sv
// APB3 register bank driving GPIO modes/data and PWM timers, with shadowed
// period/duty commit and rising-edge input interrupts.
module gpio_pwm_apb_regs
  import gpio_pwm_pkg::*;
#(
  parameter int unsigned GPIO_PORT_NUM = 32,
  parameter int unsigned CNT_LENGTH    = 16,
  parameter int unsigned TIM_NUM       = 8,
  parameter int unsigned ADDR_WIDTH    = 8
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  gpio_pwm_apb_regs_if.slave              apb,
  output logic [TIM_NUM-1:0]              pwm_en,
  output logic [TIM_NUM*CNT_LENGTH-1:0]   max_val_flat,
  output logic [TIM_NUM*CNT_LENGTH-1:0]   duty_cycle_flat,
  output logic [GPIO_PORT_NUM-1:0]        ctrl_in_sel,
  output logic [GPIO_PORT_NUM-1:0]        ctrl_af_sel,
  output logic [GPIO_PORT_NUM-1:0]        ctrl_od_sel,
  output logic [GPIO_PORT_NUM-1:0]        ctrl_lo_sel,
  output logic [GPIO_PORT_NUM-1:0]        gpio_output,
  input  logic [GPIO_PORT_NUM-1:0]        gpio_input,
  output logic                            irq
);

  localparam int unsigned TIDX_W = (TIM_NUM > 1) ? $clog2(TIM_NUM) : 1;
  localparam logic [PWM_UPD_W-1:0] TIM_MASK = PWM_UPD_W'((64'd1 << TIM_NUM) - 64'd1);

  logic [ADDR_WIDTH-1:0]                  addr;
  logic [31:0]                            a32;
  logic [31:0]                            tnum;
  logic [TIDX_W-1:0]                      tidx;
  reg_sel_e                               sel;
  logic                                   err;
  logic                                   setup;
  logic                                   wr_en;
  logic                                   upd_any;
  logic                                   upd_hit;
  logic [APB_DATA_W-1:0]                  rdata;
  logic [GPIO_PORT_NUM-1:0]               in_sync;
  logic [GPIO_PORT_NUM-1:0]               in_rise;
  logic [GPIO_PORT_NUM-1:0]               irq_en;
  logic [GPIO_PORT_NUM-1:0]               irq_stat;
  logic [GPIO_PORT_NUM-1:0]               irq_clr;
  logic [TIM_NUM-1:0][CNT_LENGTH-1:0]     max_shadow;
  logic [TIM_NUM-1:0][CNT_LENGTH-1:0]     duty_shadow;
  logic [TIM_NUM-1:0][CNT_LENGTH-1:0]     max_live;
  logic [TIM_NUM-1:0][CNT_LENGTH-1:0]     duty_live;

  gpio_in_sync #(.GPIO_PORT_NUM(GPIO_PORT_NUM)) u_in_sync (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .gpio_input (gpio_input),
    .sync_val   (in_sync),
    .rise       (in_rise)
  );

  assign addr            = apb.paddr;
  assign a32             = 32'(addr);
  assign tnum            = (a32 - SHADOW_BASE) / SHADOW_STRIDE;
  assign setup           = apb.psel & ~apb.penable;
  assign max_val_flat    = max_live;
  assign duty_cycle_flat = duty_live;
  assign upd_any         = |apb.pwdata;
  assign upd_hit         = |(apb.pwdata[PWM_UPD_W-1:0] & TIM_MASK);

  // Address decode: word-aligned fixed registers below the shadow bank
  always_comb begin
    sel  = SEL_NONE;
    tidx = '0;
    if (a32[1:0] == 2'b00) begin
      if (a32 >= SHADOW_BASE) begin
        if (tnum < TIM_NUM) begin
          sel  = a32[2] ? SEL_DUTY : SEL_MAX;
          tidx = TIDX_W'(tnum);
        end
      end else begin
        case (a32)
          OFF_OUT:      sel = SEL_OUT;
          OFF_IN:       sel = SEL_IN;
          OFF_IN_SEL:   sel = SEL_IN_SEL;
          OFF_AF_SEL:   sel = SEL_AF_SEL;
          OFF_OD_SEL:   sel = SEL_OD_SEL;
          OFF_LO_SEL:   sel = SEL_LO_SEL;
          OFF_PWM_EN:   sel = SEL_PWM_EN;
          OFF_PWM_UPD:  sel = SEL_PWM_UPD;
          OFF_IRQ_EN:   sel = SEL_IRQ_EN;
          OFF_IRQ_STAT: sel = SEL_IRQ_STAT;
          default:      sel = SEL_NONE;
        endcase
      end
    end
  end

  // A commit word is only rejected when every set bit names a missing timer
  always_comb begin
    err = (sel == SEL_NONE)
        | (apb.pwrite  && sel == SEL_IN)
        | (!apb.pwrite && sel == SEL_PWM_UPD)
        | (apb.pwrite  && sel == SEL_PWM_UPD && upd_any && !upd_hit);
  end

  assign wr_en   = apb.psel & apb.penable & apb.pwrite & ~err;
  assign irq_clr = (wr_en && sel == SEL_IRQ_STAT) ? GPIO_PORT_NUM'(apb.pwdata) : '0;

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_OUT:      rdata = 32'(gpio_output);
      SEL_IN:       rdata = 32'(in_sync);
      SEL_IN_SEL:   rdata = 32'(ctrl_in_sel);
      SEL_AF_SEL:   rdata = 32'(ctrl_af_sel);
      SEL_OD_SEL:   rdata = 32'(ctrl_od_sel);
      SEL_LO_SEL:   rdata = 32'(ctrl_lo_sel);
      SEL_PWM_EN:   rdata = 32'(pwm_en);
      SEL_IRQ_EN:   rdata = 32'(irq_en);
      SEL_IRQ_STAT: rdata = IRQ_STAT_W'(irq_stat);
      SEL_MAX:      rdata = 32'(max_shadow[tidx]);
      SEL_DUTY:     rdata = 32'(duty_shadow[tidx]);
      default:      rdata = '0;
    endcase
  end

  // Read response is captured in setup; writes land at the end of access
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      apb.prdata  <= '0;
      apb.pready  <= 1'b0;
      apb.pslverr <= 1'b0;
      gpio_output <= '0;
      ctrl_in_sel <= '1;
      ctrl_af_sel <= '0;
      ctrl_od_sel <= '0;
      ctrl_lo_sel <= '0;
      pwm_en      <= '0;
      irq_en      <= '0;
      irq_stat    <= '0;
      irq         <= 1'b0;
      max_shadow  <= '0;
      duty_shadow <= '0;
      max_live    <= '0;
      duty_live   <= '0;
    end else begin
      apb.pready  <= setup;
      apb.pslverr <= setup & err;
      if (setup) begin
        apb.prdata <= apb.pwrite ? '0 : rdata;
      end
      irq_stat <= (irq_stat & ~irq_clr) | in_rise;
      irq      <= |(irq_stat & irq_en);
      if (wr_en) begin
        case (sel)
          SEL_OUT:    gpio_output <= GPIO_PORT_NUM'(apb.pwdata);
          SEL_IN_SEL: ctrl_in_sel <= GPIO_PORT_NUM'(apb.pwdata);
          SEL_AF_SEL: ctrl_af_sel <= GPIO_PORT_NUM'(apb.pwdata);
          SEL_OD_SEL: ctrl_od_sel <= GPIO_PORT_NUM'(apb.pwdata);
          SEL_LO_SEL: ctrl_lo_sel <= GPIO_PORT_NUM'(apb.pwdata);
          SEL_PWM_EN: pwm_en      <= TIM_NUM'(apb.pwdata);
          SEL_IRQ_EN: irq_en      <= GPIO_PORT_NUM'(apb.pwdata);
          SEL_MAX:    max_shadow[tidx]  <= CNT_LENGTH'(apb.pwdata);
          SEL_DUTY:   duty_shadow[tidx] <= CNT_LENGTH'(apb.pwdata);
          SEL_PWM_UPD: begin
            for (int i = 0; i < TIM_NUM; i++) begin
              if (apb.pwdata[i]) begin
                max_live[i]  <= max_shadow[i];
                duty_live[i] <= duty_shadow[i];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_pwm_apb_regs.sv
// Self-checking bench for gpio_pwm_apb_regs: table-driven register accesses
// with a response scoreboard, plus hand-timed interrupt and reset sequences.
module tb_gpio_pwm_apb_regs;

  localparam int unsigned GPIO_PORT_NUM = 32;
  localparam int unsigned CNT_LENGTH    = 16;
  localparam int unsigned TIM_NUM       = 8;
  localparam int unsigned ADDR_WIDTH    = 8;

  logic                          sys_clk = 1'b0;
  logic                          sys_rst_n = 1'b0;
  logic [TIM_NUM-1:0]            pwm_en;
  logic [TIM_NUM*CNT_LENGTH-1:0] max_val_flat;
  logic [TIM_NUM*CNT_LENGTH-1:0] duty_cycle_flat;
  logic [GPIO_PORT_NUM-1:0]      ctrl_in_sel, ctrl_af_sel, ctrl_od_sel, ctrl_lo_sel;
  logic [GPIO_PORT_NUM-1:0]      gpio_output;
  logic [GPIO_PORT_NUM-1:0]      gpio_input;
  logic                          irq;

  gpio_pwm_apb_regs_if #(.ADDR_WIDTH(ADDR_WIDTH)) apb ();

  gpio_pwm_apb_regs #(
    .GPIO_PORT_NUM(GPIO_PORT_NUM), .CNT_LENGTH(CNT_LENGTH),
    .TIM_NUM(TIM_NUM), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .apb             (apb),
    .pwm_en          (pwm_en),
    .max_val_flat    (max_val_flat),
    .duty_cycle_flat (duty_cycle_flat),
    .ctrl_in_sel     (ctrl_in_sel),
    .ctrl_af_sel     (ctrl_af_sel),
    .ctrl_od_sel     (ctrl_od_sel),
    .ctrl_lo_sel     (ctrl_lo_sel),
    .gpio_output     (gpio_output),
    .gpio_input      (gpio_input),
    .irq             (irq)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
    string       name;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] rd;
    logic        err;
    string       name;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t tab[$];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One zero-wait APB transfer; response checked in the access phase
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input string name);
    exp_t e;
    sb.push_back('{wr, exp_rd, exp_err, name});
    apb.paddr   = addr;
    apb.pwrite  = wr;
    apb.pwdata  = wdata;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    tick();
    apb.penable = 1'b1;
    e = sb.pop_front();
    check({e.name, " pready"}, 128'(apb.pready), 128'(1'b1));
    check({e.name, " pslverr"}, 128'(apb.pslverr), 128'(e.err));
    if (!e.wr) check({e.name, " prdata"}, 128'(apb.prdata), 128'(e.rd));
    tick();
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
  endtask

  task automatic run_table();
    foreach (tab[i]) apb_xfer(tab[i].wr, tab[i].addr, tab[i].wdata, tab[i].rd, tab[i].err, tab[i].name);
    tab.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    apb.paddr = '0; apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.pwdata = '0;
    gpio_input = '0;
    tick(); tick();
    check("rst pready", 128'(apb.pready), 128'(0));
    check("rst in_sel", 128'(ctrl_in_sel), 128'hFFFF_FFFF);
    check("rst gpio_output", 128'(gpio_output), 128'(0));
    check("rst irq", 128'(irq), 128'(0));
    sys_rst_n = 1'b1;
    tick();

    // Reset values of every mapped register, plus unmapped offsets
    tab.push_back('{1'b0, 8'h00, 32'h0, 32'h0,         1'b0, "rst rd OUT"});
    tab.push_back('{1'b0, 8'h04, 32'h0, 32'h0,         1'b0, "rst rd IN"});
    tab.push_back('{1'b0, 8'h08, 32'h0, 32'hFFFF_FFFF, 1'b0, "rst rd IN_SEL"});
    tab.push_back('{1'b0, 8'h0C, 32'h0, 32'h0,         1'b0, "rst rd AF_SEL"});
    tab.push_back('{1'b0, 8'h10, 32'h0, 32'h0,         1'b0, "rst rd OD_SEL"});
    tab.push_back('{1'b0, 8'h14, 32'h0, 32'h0,         1'b0, "rst rd LO_SEL"});
    tab.push_back('{1'b0, 8'h18, 32'h0, 32'h0,         1'b0, "rst rd PWM_EN"});
    tab.push_back('{1'b0, 8'h1C, 32'h0, 32'h0,         1'b1, "rst rd PWM_UPD"});
    tab.push_back('{1'b0, 8'h20, 32'h0, 32'h0,         1'b0, "rst rd IRQ_EN"});
    tab.push_back('{1'b0, 8'h24, 32'h0, 32'h0,         1'b0, "rst rd IRQ_STAT"});
    tab.push_back('{1'b0, 8'h40, 32'h0, 32'h0,         1'b0, "rst rd MAX0"});
    tab.push_back('{1'b0, 8'h7C, 32'h0, 32'h0,         1'b0, "rst rd DUTY7"});
    tab.push_back('{1'b0, 8'h2C, 32'h0, 32'h0,         1'b1, "rd unmapped 2C"});
    tab.push_back('{1'b0, 8'h80, 32'h0, 32'h0,         1'b1, "rd timer8"});
    run_table();

    // Writes/readbacks across register kinds, including erroring writes
    tab.push_back('{1'b1, 8'h08, 32'h1234_5678, 32'h0,          1'b0, "wr IN_SEL"});
    tab.push_back('{1'b0, 8'h08, 32'h0,         32'h1234_5678,  1'b0, "rd IN_SEL"});
    tab.push_back('{1'b1, 8'h0C, 32'hFFFF_0000, 32'h0,          1'b0, "wr AF_SEL"});
    tab.push_back('{1'b0, 8'h0C, 32'h0,         32'hFFFF_0000,  1'b0, "rd AF_SEL"});
    tab.push_back('{1'b1, 8'h14, 32'h00FF_00FF, 32'h0,          1'b0, "wr LO_SEL"});
    tab.push_back('{1'b0, 8'h14, 32'h0,         32'h00FF_00FF,  1'b0, "rd LO_SEL"});
    tab.push_back('{1'b1, 8'h18, 32'h1234_5681, 32'h0,          1'b0, "wr PWM_EN"});
    tab.push_back('{1'b0, 8'h18, 32'h0,         32'h0000_0081,  1'b0, "rd PWM_EN"});
    tab.push_back('{1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0,          1'b1, "wr IN"});
    tab.push_back('{1'b0, 8'h04, 32'h0,         32'h0,          1'b0, "rd IN after wr"});
    tab.push_back('{1'b1, 8'h1C, 32'h0000_0100, 32'h0,          1'b1, "wr UPD out of range"});
    tab.push_back('{1'b1, 8'h2C, 32'hDEAD_BEEF, 32'h0,          1'b1, "wr unmapped"});
    tab.push_back('{1'b1, 8'h48, 32'hABCD_1234, 32'h0,          1'b0, "wr MAX1"});
    tab.push_back('{1'b0, 8'h48, 32'h0,         32'h0000_1234,  1'b0, "rd MAX1"});
    tab.push_back('{1'b1, 8'h84, 32'h0000_5555, 32'h0,          1'b1, "wr DUTY8"});
    run_table();
    check("port in_sel", 128'(ctrl_in_sel), 128'h1234_5678);
    check("port af_sel", 128'(ctrl_af_sel), 128'hFFFF_0000);
    check("port lo_sel", 128'(ctrl_lo_sel), 128'h00FF_00FF);
    check("port pwm_en", 128'(pwm_en), 128'h81);

    apb_xfer(1'b1, 8'h00, 32'hA5A5_A5A5, 32'h0, 1'b0, "wr OUT");
    check("port gpio_output", 128'(gpio_output), 128'hA5A5_A5A5);
    apb_xfer(1'b1, 8'h10, 32'h0000_000F, 32'h0, 1'b0, "wr OD_SEL");
    check("port od_sel", 128'(ctrl_od_sel), 128'hF);
    apb_xfer(1'b0, 8'h00, 32'h0, 32'hA5A5_A5A5, 1'b0, "rd OUT");

    // Shadow writes stay invisible until committed
    apb_xfer(1'b1, 8'h50, 32'h0000_03E8, 32'h0, 1'b0, "wr MAX2");
    apb_xfer(1'b1, 8'h54, 32'h0000_01F4, 32'h0, 1'b0, "wr DUTY2");
    check("live max before upd", max_val_flat, 128'h0);
    check("live duty before upd", duty_cycle_flat, 128'h0);
    apb_xfer(1'b0, 8'h50, 32'h0, 32'h0000_03E8, 1'b0, "rd MAX2 shadow");
    apb_xfer(1'b1, 8'h1C, 32'h0000_0004, 32'h0, 1'b0, "wr UPD t2");
    check("live max after upd", max_val_flat, 128'h03E8_0000_0000);
    check("live duty after upd", duty_cycle_flat, 128'h01F4_0000_0000);
    apb_xfer(1'b1, 8'h50, 32'h0000_0777, 32'h0, 1'b0, "wr MAX2 again");
    check("live max holds", max_val_flat, 128'h03E8_0000_0000);
    apb_xfer(1'b1, 8'h1C, 32'h0000_0104, 32'h0, 1'b0, "wr UPD mixed range");
    check("live max mixed upd", max_val_flat, 128'h0777_0000_0000);

    // Input edge to irq latency on pin 0
    apb_xfer(1'b1, 8'h20, 32'h0000_0001, 32'h0, 1'b0, "wr IRQ_EN 1");
    gpio_input[0] = 1'b1;
    tick(); tick(); tick(); tick();
    check("irq after 4 edges", 128'(irq), 128'(0));
    tick();
    check("irq after 5 edges", 128'(irq), 128'(1));
    apb_xfer(1'b0, 8'h04, 32'h0, 32'h0000_0001, 1'b0, "rd IN pin0");
    apb_xfer(1'b0, 8'h24, 32'h0, 32'h0000_0001, 1'b0, "rd IRQ_STAT pin0");
    apb_xfer(1'b1, 8'h24, 32'h0000_0001, 32'h0, 1'b0, "clr IRQ_STAT 1");
    check("irq at clear edge", 128'(irq), 128'(1));
    tick();
    check("irq after clear", 128'(irq), 128'(0));
    apb_xfer(1'b0, 8'h24, 32'h0, 32'h0, 1'b0, "rd IRQ_STAT cleared");

    // Pin 5 rises on the same edge as a rw1c clear of bit 5
    gpio_input[5] = 1'b1;
    tick(); tick();
    apb_xfer(1'b1, 8'h24, 32'h0000_0020, 32'h0, 1'b0, "clr IRQ_STAT 20 collide");
    apb_xfer(1'b0, 8'h24, 32'h0, 32'h0000_0020, 1'b0, "rd IRQ_STAT set wins");
    check("irq masked pin5", 128'(irq), 128'(0));

    // Enabling then disabling bit 5 toggles irq without touching status
    apb_xfer(1'b1, 8'h20, 32'h0000_0020, 32'h0, 1'b0, "wr IRQ_EN 20");
    tick();
    check("irq unmasked", 128'(irq), 128'(1));
    apb_xfer(1'b1, 8'h20, 32'h0000_0000, 32'h0, 1'b0, "wr IRQ_EN 0");
    tick();
    check("irq after en clear", 128'(irq), 128'(0));
    apb_xfer(1'b0, 8'h24, 32'h0, 32'h0000_0020, 1'b0, "rd IRQ_STAT kept");

    // Reset pulse during the access phase of a write
    apb_xfer(1'b1, 8'h20, 32'h0000_0020, 32'h0, 1'b0, "wr IRQ_EN 20 pre-rst");
    tick();
    check("irq pre-rst", 128'(irq), 128'(1));
    apb.paddr = 8'h00; apb.pwrite = 1'b1; apb.pwdata = 32'hFFFF_FFFF;
    apb.psel = 1'b1; apb.penable = 1'b0;
    tick();
    apb.penable = 1'b1;
    sys_rst_n   = 1'b0;
    tick();
    sys_rst_n   = 1'b1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    check("rst2 gpio_output", 128'(gpio_output), 128'h0);
    check("rst2 in_sel", 128'(ctrl_in_sel), 128'hFFFF_FFFF);
    check("rst2 af_sel", 128'(ctrl_af_sel), 128'h0);
    check("rst2 od_sel", 128'(ctrl_od_sel), 128'h0);
    check("rst2 pwm_en", 128'(pwm_en), 128'h0);
    check("rst2 max", max_val_flat, 128'h0);
    check("rst2 duty", duty_cycle_flat, 128'h0);
    check("rst2 irq", 128'(irq), 128'(0));
    check("rst2 pready", 128'(apb.pready), 128'(0));
    check("rst2 pslverr", 128'(apb.pslverr), 128'(0));
    check("rst2 prdata", 128'(apb.prdata), 128'h0);
    tick(); tick(); tick(); tick(); tick(); tick();
    check("rst2 irq stays low", 128'(irq), 128'(0));
    tab.push_back('{1'b0, 8'h20, 32'h0, 32'h0,         1'b0, "rst2 rd IRQ_EN"});
    tab.push_back('{1'b0, 8'h50, 32'h0, 32'h0,         1'b0, "rst2 rd MAX2"});
    tab.push_back('{1'b0, 8'h08, 32'h0, 32'hFFFF_FFFF, 1'b0, "rst2 rd IN_SEL"});
    tab.push_back('{1'b0, 8'h04, 32'h0, 32'h0000_0021, 1'b0, "rst2 rd IN"});
    run_table();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
